// File: rtl/parking_lot_multi_gate.sv
// rtl/parking_lot_multi_gate.sv - multi-lane parking-lot gate controller with debounced sensors and shared occupancy
// Ports: clk, reset (sync, active-low); sens_a/sens_b raw outer/inner beams per lane;
//        entering/exiting/reject/stall one-cycle pulses per lane; count occupancy;
//        full/empty flags; err sticky underflow flag.
// Optional lane watchdog: define PARKING_LOT_TIMEOUT_EN (otherwise stall is tied low).
module parking_lot_multi_gate #(
    parameter int LANES     = 2,
    parameter int CAP       = 64,
    parameter int CNT_W     = 7,
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] sens_a,
    input  logic [LANES-1:0] sens_b,
    output logic [LANES-1:0] entering,
    output logic [LANES-1:0] exiting,
    output logic [LANES-1:0] reject,
    output logic [LANES-1:0] stall,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int NS  = 2 * LANES;
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAP);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IN_A   = 3'd1;
    localparam logic [2:0] S_IN_AB  = 3'd2;
    localparam logic [2:0] S_IN_B   = 3'd3;
    localparam logic [2:0] S_OUT_B  = 3'd4;
    localparam logic [2:0] S_OUT_AB = 3'd5;
    localparam logic [2:0] S_OUT_A  = 3'd6;

    if (LANES < 1 || LANES > 8 || DB_CYCLES < 1 || TIMEOUT < 1 || (2 ** CNT_W) <= CAP) begin : g_bad_param
        $error("parking_lot_multi_gate: illegal parameter combination");
    end

    // Debouncers: bits [LANES-1:0] are the a sensors, [NS-1:LANES] the b sensors.
    logic [NS-1:0]  raw_q, db_q, db_d;
    logic [DBW-1:0] run_q [NS];
    logic [DBW-1:0] run_d [NS];

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            db_d[s]  = db_q[s];
            run_d[s] = '0;
            if (raw_q[s] != db_q[s]) begin
                if (run_q[s] == DB_LAST) db_d[s] = raw_q[s];
                else                     run_d[s] = run_q[s] + 1'b1;
            end
        end
    end

    // Lane sequence FSMs
    logic [2:0]       st_q [LANES];
    logic [2:0]       st_d [LANES];
    logic [LANES-1:0] ent_req, ex_req, stall_d;

`ifdef PARKING_LOT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT);
    logic [WDW-1:0] wd_q [LANES];
    logic [WDW-1:0] wd_d [LANES];
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic a, b;
            a = db_q[i];
            b = db_q[LANES + i];
            st_d[i]    = st_q[i];
            ent_req[i] = 1'b0;
            ex_req[i]  = 1'b0;
            stall_d[i] = 1'b0;
            case (st_q[i])
                S_IDLE:   if (a && !b) st_d[i] = S_IN_A;
                          else if (!a && b) st_d[i] = S_OUT_B;
                S_IN_A:   if (a && b) st_d[i] = S_IN_AB;
                          else if (!a && !b) st_d[i] = S_IDLE;
                S_IN_AB:  if (!a && b) st_d[i] = S_IN_B;
                          else if (a && !b) st_d[i] = S_IN_A;
                          else if (!a && !b) st_d[i] = S_IDLE;
                S_IN_B:   if (!a && !b) begin
                              st_d[i]    = S_IDLE;
                              ent_req[i] = 1'b1;
                          end else if (a) st_d[i] = S_IN_AB;
                S_OUT_B:  if (a && b) st_d[i] = S_OUT_AB;
                          else if (!a && !b) st_d[i] = S_IDLE;
                S_OUT_AB: if (a && !b) st_d[i] = S_OUT_A;
                          else if (!a && b) st_d[i] = S_OUT_B;
                          else if (!a && !b) st_d[i] = S_IDLE;
                S_OUT_A:  if (!a && !b) begin
                              st_d[i]   = S_IDLE;
                              ex_req[i] = 1'b1;
                          end else if (b) st_d[i] = S_OUT_AB;
                default:  st_d[i] = S_IDLE;
            endcase
`ifdef PARKING_LOT_TIMEOUT_EN
            // The watchdog wins over a completion landing in the same cycle.
            wd_d[i] = '0;
            if (st_q[i] != S_IDLE) begin
                if (wd_q[i] == WD_LIM) begin
                    st_d[i]    = S_IDLE;
                    ent_req[i] = 1'b0;
                    ex_req[i]  = 1'b0;
                    stall_d[i] = 1'b1;
                end else begin
                    wd_d[i] = wd_q[i] + 1'b1;
                end
            end
`endif
        end
    end

    // Occupancy arbitration: exits first, then entries in ascending lane order.
    logic [CNT_W-1:0] cnt_q, tent;
    logic             full_q, empty_q, err_q, err_d;
    logic [LANES-1:0] ent_q, ex_q, rej_q, stall_q;
    logic [LANES-1:0] ent_d, ex_d, rej_d;

    always_comb begin
        tent  = cnt_q;
        err_d = err_q;
        ent_d = '0;
        ex_d  = '0;
        rej_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ex_req[i]) begin
                if (tent != '0) begin
                    tent    = tent - 1'b1;
                    ex_d[i] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (ent_req[i]) begin
                if (tent < CAP_V) begin
                    tent     = tent + 1'b1;
                    ent_d[i] = 1'b1;
                end else begin
                    rej_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            raw_q   <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
            ent_q   <= '0;
            ex_q    <= '0;
            rej_q   <= '0;
            stall_q <= '0;
            for (int s = 0; s < NS; s++) run_q[s] <= '0;
            for (int i = 0; i < LANES; i++) begin
                st_q[i] <= S_IDLE;
`ifdef PARKING_LOT_TIMEOUT_EN
                wd_q[i] <= '0;
`endif
            end
        end else begin
            raw_q   <= {sens_b, sens_a};
            db_q    <= db_d;
            cnt_q   <= tent;
            full_q  <= (tent == CAP_V);
            empty_q <= (tent == '0);
            err_q   <= err_d;
            ent_q   <= ent_d;
            ex_q    <= ex_d;
            rej_q   <= rej_d;
            stall_q <= stall_d;
            for (int s = 0; s < NS; s++) run_q[s] <= run_d[s];
            for (int i = 0; i < LANES; i++) begin
                st_q[i] <= st_d[i];
`ifdef PARKING_LOT_TIMEOUT_EN
                wd_q[i] <= wd_d[i];
`endif
            end
        end
    end

    assign entering = ent_q;
    assign exiting  = ex_q;
    assign reject   = rej_q;
    assign stall    = stall_q;
    assign count    = cnt_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign err      = err_q;

endmodule

// File: tb/tb_parking_lot_multi_gate.sv
// tb/tb_parking_lot_multi_gate.sv - self-checking bench for parking_lot_multi_gate
module tb_parking_lot_multi_gate;

    localparam int LANES    = 3;
    localparam int CAP      = 5;
    localparam int CNT_W    = 3;
    localparam int DB       = 4;
    localparam int HOLD     = 10;
    localparam int PULSE_AT = DB + 2;
    localparam int NPH      = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [LANES-1:0] sens_a, sens_b;
    logic [LANES-1:0] entering, exiting, reject, stall;
    logic [CNT_W-1:0] count;
    logic             full, empty, err;

    parking_lot_multi_gate #(
        .LANES(LANES), .CAP(CAP), .CNT_W(CNT_W), .DB_CYCLES(DB), .TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
        .entering(entering), .exiting(exiting), .reject(reject), .stall(stall),
        .count(count), .full(full), .empty(empty), .err(err)
    );

    // Single-lane instance with a short watchdog for the timeout check.
    logic [0:0]       t_sens_a, t_sens_b, t_entering, t_exiting, t_reject, t_stall;
    logic [CNT_W-1:0] t_count;
    logic             t_full, t_empty, t_err;

    parking_lot_multi_gate #(
        .LANES(1), .CAP(CAP), .CNT_W(CNT_W), .DB_CYCLES(DB), .TIMEOUT(20)
    ) dut_to (
        .clk(clk), .reset(reset), .sens_a(t_sens_a), .sens_b(t_sens_b),
        .entering(t_entering), .exiting(t_exiting), .reject(t_reject), .stall(t_stall),
        .count(t_count), .full(t_full), .empty(t_empty), .err(t_err)
    );

    logic [17:0] obs;
    assign obs = {entering, exiting, reject, stall, count, full, empty, err};

    typedef struct {
        logic [8:0] codes;
        logic [2:0] ent;
        logic [2:0] ex;
        logic [2:0] rej;
        int         cnt;
        logic       err;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    logic m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] expv(input logic [2:0] en, input logic [2:0] ex,
                                         input logic [2:0] rj, input int c, input logic e);
        logic [2:0] c3;
        c3 = c[2:0];
        return {en, ex, rj, 3'b000, c3, (c == CAP), (c == 0), e};
    endfunction

    // Lane scenarios as sequences of {a,b} patterns, right-aligned to NPH phases:
    // 0 idle, 1 entry, 2 exit, 3 aborted entry, 4 aborted exit,
    // 5 entry that backs up into ab once, 6 a straight to b (no ab) -> no count.
    function automatic logic [1:0] pat(input int code, input int ph);
        logic [1:0] s [NPH];
        int n, idx;
        s = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        n = 1;
        case (code)
            1: begin s = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00}; n = 4; end
            2: begin s = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}; n = 4; end
            3: begin s = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00}; n = 4; end
            4: begin s = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00}; n = 4; end
            5: begin s = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00}; n = 6; end
            6: begin s = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00}; n = 3; end
            default: n = 1;
        endcase
        idx = ph - (NPH - n);
        return (idx < 0) ? 2'b00 : s[idx];
    endfunction

    // Reference model: spec arbitration rules in plain arithmetic.
    task automatic model(input logic [8:0] codes, output vec_t v);
        int t;
        logic e;
        t = m_cnt;
        e = m_err;
        v.codes = codes;
        v.ent = '0; v.ex = '0; v.rej = '0;
        for (int l = 0; l < LANES; l++) begin
            if (codes[3*l +: 3] == 3'd2) begin
                if (t > 0) begin t--; v.ex[l] = 1'b1; end
                else e = 1'b1;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (codes[3*l +: 3] == 3'd1 || codes[3*l +: 3] == 3'd5) begin
                if (t < CAP) begin t++; v.ent[l] = 1'b1; end
                else v.rej[l] = 1'b1;
            end
        end
        v.cnt = t;
        v.err = e;
    endtask

    task automatic run_round(input string tag, input vec_t v);
        logic [17:0] old_v, exp_v;
        logic [1:0]  p;
        old_v = expv(3'b0, 3'b0, 3'b0, m_cnt, m_err);
        for (int ph = 0; ph < NPH; ph++) begin
            for (int l = 0; l < LANES; l++) begin
                p = pat(int'(v.codes[3*l +: 3]), ph);
                sens_a[l] = p[1];
                sens_b[l] = p[0];
            end
            for (int c = 1; c <= HOLD; c++) begin
                @(posedge clk); #1;
                if (ph < NPH - 1 || c < PULSE_AT) exp_v = old_v;
                else if (c == PULSE_AT)           exp_v = expv(v.ent, v.ex, v.rej, v.cnt, v.err);
                else                              exp_v = expv(3'b0, 3'b0, 3'b0, v.cnt, v.err);
                chk(tag, {14'b0, obs}, {14'b0, exp_v});
            end
        end
        m_cnt = v.cnt;
        m_err = v.err;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            chk(tag, {14'b0, obs}, {14'b0, expv(3'b0, 3'b0, 3'b0, m_cnt, m_err)});
        end
    endtask

    vec_t tbl [10];
    vec_t rv;

    initial begin
        tbl[0] = '{codes: 9'o001, ent: 3'b001, ex: 3'b000, rej: 3'b000, cnt: 1, err: 1'b0};
        tbl[1] = '{codes: 9'o011, ent: 3'b011, ex: 3'b000, rej: 3'b000, cnt: 3, err: 1'b0};
        tbl[2] = '{codes: 9'o632, ent: 3'b000, ex: 3'b001, rej: 3'b000, cnt: 2, err: 1'b0};
        tbl[3] = '{codes: 9'o105, ent: 3'b101, ex: 3'b000, rej: 3'b000, cnt: 4, err: 1'b0};
        tbl[4] = '{codes: 9'o011, ent: 3'b001, ex: 3'b000, rej: 3'b010, cnt: 5, err: 1'b0};
        tbl[5] = '{codes: 9'o121, ent: 3'b001, ex: 3'b010, rej: 3'b100, cnt: 5, err: 1'b0};
        tbl[6] = '{codes: 9'o222, ent: 3'b000, ex: 3'b111, rej: 3'b000, cnt: 2, err: 1'b0};
        tbl[7] = '{codes: 9'o422, ent: 3'b000, ex: 3'b011, rej: 3'b000, cnt: 0, err: 1'b0};
        tbl[8] = '{codes: 9'o002, ent: 3'b000, ex: 3'b000, rej: 3'b000, cnt: 0, err: 1'b1};
        tbl[9] = '{codes: 9'o134, ent: 3'b100, ex: 3'b000, rej: 3'b000, cnt: 1, err: 1'b1};

        reset = 1'b0;
        sens_a = '0; sens_b = '0;
        t_sens_a = '0; t_sens_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {14'b0, obs}, {14'b0, expv(3'b0, 3'b0, 3'b0, 0, 1'b0)});
        chk("reset_state_to", {t_entering, t_exiting, t_reject, t_stall, t_count, t_full, t_empty, t_err},
            {4'b0, 3'd0, 1'b0, 1'b1, 1'b0});
        reset = 1'b1;

        // Bounce on sens_a[0]: toggles every 2 cycles never survive the debouncer.
        for (int c = 0; c < 20; c++) begin
            sens_a[0] = c[1];
            @(posedge clk); #1;
            chk("bounce", {14'b0, obs}, {14'b0, expv(3'b0, 3'b0, 3'b0, m_cnt, m_err)});
        end
        sens_a[0] = 1'b0;
        idle_cycles("bounce_settle", HOLD);

        for (int r = 0; r < 10; r++) run_round($sformatf("table_row%0d", r), tbl[r]);

        // One-cycle reset clears the sticky err and the count.
        reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_clears_err", {14'b0, obs}, {14'b0, expv(3'b0, 3'b0, 3'b0, 0, 1'b0)});
        reset = 1'b1;
        m_cnt = 0;
        m_err = 1'b0;

        // A car mid-entry when reset hits is forgotten.
        sens_a[0] = 1'b1;               idle_cycles("midreset_a", HOLD);
        sens_b[0] = 1'b1;               idle_cycles("midreset_ab", HOLD);
        sens_a[0] = 1'b0;               idle_cycles("midreset_b", HOLD);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles("midreset_hold", 2);
        sens_b[0] = 1'b0;               idle_cycles("midreset_release", 2 * HOLD);

        for (int r = 0; r < 40; r++) begin
            logic [8:0] codes;
            for (int l = 0; l < LANES; l++) codes[3*l +: 3] = 3'($urandom_range(6, 0));
            model(codes, rv);
            run_round($sformatf("random_round%0d", r), rv);
        end

        begin
            int n_stall;
            logic [2:0] other;
            n_stall = 0;
            other = '0;
            t_sens_a = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                n_stall += int'(t_stall);
                other |= {t_entering, t_exiting, t_reject};
            end
            t_sens_a = 1'b0;
            for (int c = 0; c < 15; c++) begin
                @(posedge clk); #1;
                n_stall += int'(t_stall);
                other |= {t_entering, t_exiting, t_reject};
            end
`ifdef PARKING_LOT_TIMEOUT_EN
            chk("timeout_stall_count", n_stall, 1);
`else
            chk("timeout_stall_count", n_stall, 0);
`endif
            chk("timeout_no_events", {29'b0, other}, 0);
            chk("timeout_count", {29'b0, t_count}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_lot_multi_gate.md
# parking_lot_multi_gate

Parametrised multi-lane parking-lot controller. Each lane has two beam sensors, outer `a` and inner `b`, with built-in per-sensor debouncers and a direction-detecting sequence FSM. A shared occupancy counter has capacity limiting, full/empty flags and a guard against underflow. It replaces the single-lane debouncer-plus-FSM top and sits between the raw gate sensors and the barrier/display logic.

## Interface
Parameters:
- `LANES`, default 2: number of gate lanes (1..8).
- `CAP`, default 64: maximum occupancy.
- `CNT_W`, default 7: counter width; must satisfy 2^CNT_W > CAP.
- `DB_CYCLES`, default 4: number of consecutive stable cycles needed for a debounced change (≥1).
- `TIMEOUT`, default 255: lane watchdog limit in cycles; used only under `PARKING_LOT_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `sens_a` in LANES: raw outer sensors, bit i = lane i, 1 = beam broken.
- `sens_b` in LANES: raw inner sensors.
- `entering` out LANES: 1-cycle pulse; an entry was accepted on lane i.
- `exiting` out LANES: 1-cycle pulse; an exit was counted on lane i.
- `reject` out LANES: 1-cycle pulse; an entry completed while the lot was at capacity and was not counted.
- `stall` out LANES: 1-cycle pulse; the lane watchdog fired. Tied to 0 when the feature is compiled out.
- `count` out CNT_W: current occupancy.
- `full` out 1: `count == CAP`.
- `empty` out 1: `count == 0`.
- `err` out 1: sticky; set when an exit completes at `count == 0`.

## Operation
- **Debouncer**, one per sensor (2·LANES in total):
  - The raw input is registered once.
  - The debounced value toggles when the registered value has differed from it for `DB_CYCLES` consecutive cycles.
  - Any interruption of that run resets the run counter.
- **Lane FSM**, per lane, driven only by the debounced `a` and `b`. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
  - IDLE: `a & !b` → IN_A; `!a & b` → OUT_B; both or neither → stay in IDLE.
  - IN_A: `a & b` → IN_AB; neither → IDLE (abort, no count); otherwise hold.
  - IN_AB: `!a & b` → IN_B; `a & !b` → IN_A; neither → IDLE (abort).
  - IN_B: neither → IDLE and raise an entry request; `a` → IN_AB; otherwise hold.
  - OUT_B, OUT_AB, OUT_A mirror the IN_* states with `a` and `b` swapped. Leaving OUT_A with neither sensor set raises an exit request.
- **Occupancy arbitration**, each cycle:
  - Let E = the set of entry requests and X = the set of exit requests.
  - Exits are evaluated first. Each exit decrements the tentative count if it is > 0. If the tentative count is already 0, the exit is not counted and `err` is set.
  - Entries are then granted in ascending lane index while the tentative count < CAP. Ungranted entries pulse `reject`.
  - `count` takes the final tentative value. It never exceeds CAP and never wraps.
- `full`, `empty` and `err` are registered and consistent with `count` in the same cycle.
- **Reset:**
  - Takes effect on the clock edge while `reset` is 0.
  - All FSMs go to IDLE, and all debounced values and run counters go to 0.
  - `count` = 0, `empty` = 1, `full` = 0, `err` = 0, and all pulse outputs are 0.
  - A mid-sequence car is forgotten; it is not counted on release of reset.

## Timing
- Raw edge to debounced edge: `DB_CYCLES + 1` cycles, given a stable input.
- Final debounced change (the edge that returns a lane to IDLE) to the `entering`/`exiting`/`reject` pulse: 1 cycle. `count`, `full` and `empty` update on the same edge as the pulse.
- Total latency from the last raw sensor release to the pulse: `DB_CYCLES + 2` cycles.
- A lane can start a new sequence in the cycle after its pulse.
- Simultaneous events on different lanes resolve in one cycle with no lost events, except the documented rejects.

## Configuration
- **`PARKING_LOT_TIMEOUT_EN` defined:**
  - Each lane has a watchdog counter, cleared in IDLE and incremented in every non-IDLE state.
  - When it reaches `TIMEOUT`, the lane is forced to IDLE with no count change, and `stall[i]` pulses for 1 cycle.
- **`PARKING_LOT_TIMEOUT_EN` undefined:** there is no watchdog, `stall` is constant 0, and lanes may stay in a non-IDLE state indefinitely.

## Test plan
- **Full entry, lane 0** (`DB_CYCLES` = 4): drive `a` → `ab` → `b` → none, each held 10 cycles. Expect `entering[0]` to pulse 6 cycles after the final release, `count` 0→1, and `empty` to drop.
- **Bounce:** toggle `sens_a` every 2 cycles for 20 cycles, then return it to 0. Expect no FSM change, no pulses, and `count` unchanged.
- **Abort:** drive `a` → `ab` → `a` → none. Expect no pulses and `count` unchanged.
- **Full lot:** set `count` = CAP−1, then complete entries on lanes 0 and 1 in the same cycle. Expect `entering[0]`, `reject[1]`, `count` = CAP and `full` = 1. An exit on lane 1 in the same cycle as 2 entries from `count` = CAP accepts lane 0 only.
- **Underflow:** with `count` = 0, complete an exit. Expect `exiting` to stay low, `err` = 1 sticky and `count` = 0. Apply `reset` = 0 for 1 cycle; expect `err` = 0.
- **Timeout** (macro on, `TIMEOUT` = 20): hold `a` only for 30 cycles. Expect `stall[0]` once, the lane back in IDLE, and `count` unchanged. With the macro off, expect no `stall` pulse.
